uart_word_assembler: RTL and testbench

- Receive-side counterpart of the 32-to-8 transmit serializer: packs four consecutive UART RX bytes into one 32-bit word.
- Sits between the UART RX module (RxData/RxDone) and user logic that consumes 32-bit words.
- A valid/ready output holding register absorbs consumer stalls.
- An inter-byte timeout discards partial words so a lost byte cannot permanently misalign framing.

---
 rtl/uart_word_assembler.sv | 190 +++++++++++++++++++
 tb/tb_uart_word_assembler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_assembler.sv
// Packs consecutive UART RX bytes into 32-bit words behind a valid/ready holding register.
// Optional XOR checksum byte (fifth byte) enabled by defining UART_WORD_ASM_CKSUM_EN.
module uart_word_assembler #(
  parameter int MSB_FIRST = 1,
  parameter int TIMEOUT   = 200000,
  parameter int TO_W      = 18
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [7:0]  RxData,
  input  logic        RxDone,
  output logic [31:0] Word,
  output logic        WordValid,
  input  logic        WordReady,
  output logic        Overrun,
  output logic        Timeout,
  output logic        ChkErr
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_B1   = 3'd1,
    S_B2   = 3'd2,
    S_B3   = 3'd3,
    S_B4   = 3'd4
  } state_e;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  function automatic logic [7:0] word_xor(input logic [31:0] w);
    word_xor = w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction

  logic          rxdone_q;
  state_e        state_q, state_d;
  logic [31:0]   shift_q, shift_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic          cmp_q, cmp_d;
  logic [31:0]   cmp_word_q, cmp_word_d;
  logic [31:0]   word_q, word_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;
  logic          tmo_q, tmo_d;
  logic          byte_stb_s;
  logic [31:0]   shifted_s;

  assign byte_stb_s = RxDone & ~rxdone_q;
  assign shifted_s  = (MSB_FIRST != 0) ? {shift_q[23:0], RxData}
                                       : {RxData, shift_q[31:8]};

`ifdef UART_WORD_ASM_CKSUM_EN
  logic chk_q, chk_d;
`endif

  // Frame assembly: byte counting, shifting, inter-byte timeout
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    to_cnt_d   = to_cnt_q;
    cmp_d      = 1'b0;
    cmp_word_d = cmp_word_q;
    tmo_d      = 1'b0;
`ifdef UART_WORD_ASM_CKSUM_EN
    chk_d      = 1'b0;
`endif
    if (state_q == S_IDLE) begin
      to_cnt_d = '0;
      if (byte_stb_s) begin
        shift_d = shifted_s;
        state_d = S_B1;
      end else begin
        state_d = S_IDLE;
      end
    end else if (byte_stb_s) begin
      // A strobe on the expiry cycle still counts as a continuation byte
      to_cnt_d = '0;
      case (state_q)
        S_B1: begin
          shift_d = shifted_s;
          state_d = S_B2;
        end
        S_B2: begin
          shift_d = shifted_s;
          state_d = S_B3;
        end
        S_B3: begin
`ifdef UART_WORD_ASM_CKSUM_EN
          shift_d    = shifted_s;
          state_d    = S_B4;
`else
          shift_d    = '0;
          state_d    = S_IDLE;
          cmp_d      = 1'b1;
          cmp_word_d = shifted_s;
`endif
        end
`ifdef UART_WORD_ASM_CKSUM_EN
        S_B4: begin
          shift_d = '0;
          state_d = S_IDLE;
          if (RxData == word_xor(shift_q)) begin
            cmp_d      = 1'b1;
            cmp_word_d = shift_q;
          end else begin
            chk_d = 1'b1;
          end
        end
`endif
        default: begin
          shift_d = '0;
          state_d = S_IDLE;
        end
      endcase
    end else if (to_cnt_q == TO_LAST) begin
      state_d  = S_IDLE;
      shift_d  = '0;
      to_cnt_d = '0;
      tmo_d    = 1'b1;
    end else begin
      to_cnt_d = to_cnt_q + TO_ONE;
    end
  end

  // Holding register: load completed word unless a stalled word is still pending
  always_comb begin
    word_d  = word_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (cmp_q) begin
      if (!valid_q || WordReady) begin
        word_d  = cmp_word_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && WordReady) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State and output registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rxdone_q   <= 1'b0;
      state_q    <= S_IDLE;
      shift_q    <= 32'h0000_0000;
      to_cnt_q   <= '0;
      cmp_q      <= 1'b0;
      cmp_word_q <= 32'h0000_0000;
      word_q     <= 32'h0000_0000;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      rxdone_q   <= RxDone;
      state_q    <= state_d;
      shift_q    <= shift_d;
      to_cnt_q   <= to_cnt_d;
      cmp_q      <= cmp_d;
      cmp_word_q <= cmp_word_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
      tmo_q      <= tmo_d;
    end
  end

`ifdef UART_WORD_ASM_CKSUM_EN
  // Checksum error pulse register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      chk_q <= 1'b0;
    end else begin
      chk_q <= chk_d;
    end
  end
  assign ChkErr = chk_q;
`else
  assign ChkErr = 1'b0;
`endif

  assign Word      = word_q;
  assign WordValid = valid_q;
  assign Overrun   = ovr_q;
  assign Timeout   = tmo_q;

endmodule

// File: tb/tb_uart_word_assembler.sv
// Bench for uart_word_assembler: instance a (MSB first, long timeout), instance b (LSB first, TIMEOUT=100).
module tb_uart_word_assembler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        word_ready;
  logic [31:0] word_a, word_b;
  logic        valid_a, valid_b, ovr_a, ovr_b, to_a, to_b, chk_a, chk_b;

  int total = 0;
  int bad = 0;
  int n_ovr_a = 0, n_ovr_b = 0, n_to_a = 0, n_to_b = 0, n_chk_a = 0, n_chk_b = 0;
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];

  always #5 clk = ~clk;

  uart_word_assembler #(.MSB_FIRST(1)) dut_a (
    .Clk(clk), .Rst_n(rst_n), .RxData(rx_data), .RxDone(rx_done),
    .Word(word_a), .WordValid(valid_a), .WordReady(word_ready),
    .Overrun(ovr_a), .Timeout(to_a), .ChkErr(chk_a)
  );

  uart_word_assembler #(.MSB_FIRST(0), .TIMEOUT(100), .TO_W(7)) dut_b (
    .Clk(clk), .Rst_n(rst_n), .RxData(rx_data), .RxDone(rx_done),
    .Word(word_b), .WordValid(valid_b), .WordReady(word_ready),
    .Overrun(ovr_b), .Timeout(to_b), .ChkErr(chk_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: compare each accepted word against the queued expectation
  always @(negedge clk) begin
    if (rst_n && word_ready && valid_a) begin
      if (q_a.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected_word: got %h expected none", word_a);
      end else begin
        check("a_word", word_a, q_a.pop_front());
      end
    end
    if (rst_n && word_ready && valid_b) begin
      if (q_b.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected_word: got %h expected none", word_b);
      end else begin
        check("b_word", word_b, q_b.pop_front());
      end
    end
    if (ovr_a) n_ovr_a++;
    if (ovr_b) n_ovr_b++;
    if (to_a)  n_to_a++;
    if (to_b)  n_to_b++;
    if (chk_a) n_chk_a++;
    if (chk_b) n_chk_b++;
  end

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    @(posedge clk); #1;
    rx_data = b;
    rx_done = 1'b1;
    repeat (hold) @(posedge clk);
    #1 rx_done = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int hold, input int gap);
    send_byte(w[31:24], hold, gap);
    send_byte(w[23:16], hold, gap);
    send_byte(w[15:8], hold, gap);
    send_byte(w[7:0], hold, gap);
`ifdef UART_WORD_ASM_CKSUM_EN
    send_byte(w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0], hold, gap);
`endif
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] bytes_in;
    logic [31:0] exp_msb;
    logic [31:0] exp_lsb;
  } vec_t;

  initial begin
    vec_t vecs[4];
    logic [7:0] last;
    int snap_a, snap_b, snap_c;
    logic early;

    vecs[0] = '{32'h1122_3344, 32'h1122_3344, 32'h4433_2211};
    vecs[1] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[2] = '{32'hA5C3_0F70, 32'hA5C3_0F70, 32'h700F_C3A5};
    vecs[3] = '{32'h1234_5678, 32'h1234_5678, 32'h7856_3412};

    rst_n = 1'b0; rx_data = 8'h00; rx_done = 1'b0; word_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_word_a", word_a, 32'h0);
    check("rst_valid_a", {31'b0, valid_a}, 32'h0);
    check("rst_flags_a", {29'b0, ovr_a, to_a, chk_a}, 32'h0);
    check("rst_word_b", word_b, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // DEADBEEF with 1000-cycle spacing on a; exact latency and one-cycle valid
    snap_a = n_ovr_a; snap_b = n_to_a;
    send_byte(8'hDE, 1, 1000);
    send_byte(8'hAD, 1, 1000);
    send_byte(8'hBE, 1, 1000);
`ifdef UART_WORD_ASM_CKSUM_EN
    send_byte(8'hEF, 1, 1000);
    last = 8'h22;
`else
    last = 8'hEF;
`endif
    q_a.push_back(32'hDEAD_BEEF);
    @(posedge clk); #1 rx_data = last; rx_done = 1'b1;
    @(negedge clk); check("lat_c0_valid", {31'b0, valid_a}, 32'h0);
    @(posedge clk); #1 rx_done = 1'b0;
    @(negedge clk); check("lat_c1_valid", {31'b0, valid_a}, 32'h0);
    @(negedge clk); check("lat_c2_valid", {31'b0, valid_a}, 32'h1);
    check("lat_c2_word", word_a, 32'hDEAD_BEEF);
    @(negedge clk); check("lat_c3_valid", {31'b0, valid_a}, 32'h0);
    check("deadbeef_no_ovr", n_ovr_a - snap_a, 32'h0);
    check("deadbeef_no_to", n_to_a - snap_b, 32'h0);
    repeat (200) @(posedge clk);

    // Same bytes, short spacing: b shows LSB-first order
    q_a.push_back(32'hDEAD_BEEF);
    q_b.push_back(32'hEFBE_ADDE);
    send_word(32'hDEAD_BEEF, 1, 10);
    repeat (5) @(posedge clk);
    check("lsb_word_b", word_b, 32'hEFBE_ADDE);

    // Overrun: consumer stalled, second word dropped
    word_ready = 1'b0;
    snap_a = n_ovr_a; snap_b = n_ovr_b;
    q_a.push_back(32'h0102_0304);
    q_b.push_back(32'h0403_0201);
    send_word(32'h0102_0304, 1, 3);
    send_word(32'h0506_0708, 1, 3);
    repeat (5) @(negedge clk);
    check("ovr_word_a", word_a, 32'h0102_0304);
    check("ovr_valid_a", {31'b0, valid_a}, 32'h1);
    check("ovr_pulses_a", n_ovr_a - snap_a, 32'h1);
    check("ovr_pulses_b", n_ovr_b - snap_b, 32'h1);
    @(posedge clk); #1 word_ready = 1'b1;
    @(posedge clk); #1 word_ready = 1'b0;
    @(negedge clk); check("ovr_drain_valid_a", {31'b0, valid_a}, 32'h0);
    word_ready = 1'b1;

    // Timeout on b after 100 idle cycles, then a clean word
    snap_a = n_to_b;
    send_byte(8'hAA, 1, 10);
    send_byte(8'hBB, 1, 0);
    early = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (to_b) early = 1'b1;
    end
    check("to_not_early", {31'b0, early}, 32'h0);
    @(negedge clk); check("to_pulse_at_100", {31'b0, to_b}, 32'h1);
    repeat (50) @(posedge clk);
`ifndef UART_WORD_ASM_CKSUM_EN
    q_a.push_back(32'hAABB_0102);
`endif
    q_b.push_back(32'h0403_0201);
    send_word(32'h0102_0304, 1, 5);
    repeat (5) @(posedge clk);
    check("to_pulse_count_b", n_to_b - snap_a, 32'h1);
    pulse_reset();

    // Reset mid-word with long RxDone levels
    q_a.push_back(32'h9988_7766);
    q_b.push_back(32'h6677_8899);
    send_word(32'h9988_7766, 20, 5);
    send_byte(8'h55, 20, 5);
    send_byte(8'h66, 20, 5);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_word_a", word_a, 32'h0);
    check("midrst_word_b", word_b, 32'h0);
    check("midrst_flags_a", {28'b0, valid_a, ovr_a, to_a, chk_a}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    snap_b = n_to_b;
    q_a.push_back(32'h1020_3040);
    q_b.push_back(32'h4030_2010);
    send_word(32'h1020_3040, 20, 5);
    repeat (5) @(posedge clk);
    check("midrst_word_after_a", word_a, 32'h1020_3040);
    check("midrst_no_to_b", n_to_b - snap_b, 32'h0);

`ifdef UART_WORD_ASM_CKSUM_EN
    // Checksum good then bad
    q_a.push_back(32'h0102_0408);
    q_b.push_back(32'h0804_0201);
    send_word(32'h0102_0408, 1, 3);
    repeat (5) @(posedge clk);
    check("ck_good_word_a", word_a, 32'h0102_0408);
    snap_c = n_chk_a;
    send_byte(8'h01, 1, 3); send_byte(8'h02, 1, 3);
    send_byte(8'h04, 1, 3); send_byte(8'h08, 1, 3);
    send_byte(8'h00, 1, 3);
    repeat (5) @(posedge clk);
    check("ck_bad_pulse_a", n_chk_a - snap_c, 32'h1);
`else
    snap_c = 0;
`endif

    // Table of frames, both byte orders
    for (int i = 0; i < 4; i++) begin
      q_a.push_back(vecs[i].exp_msb);
      q_b.push_back(vecs[i].exp_lsb);
      send_word(vecs[i].bytes_in, 1, 2);
    end
    repeat (20) @(posedge clk);
    check("q_a_drained", q_a.size(), 32'h0);
    check("q_b_drained", q_b.size(), 32'h0);
`ifndef UART_WORD_ASM_CKSUM_EN
    check("chkerr_tied_low", n_chk_a + n_chk_b + snap_c, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
